// File: rtl/ctrlread_resp_engine.sv
// rtl/ctrlread_resp_engine.sv - control-read responder: pops FIFO requests, reads memory, returns tagged responses.
// Optional WAIT timeout enabled by defining CTRLRD_TIMEOUT_EN.
module ctrlread_resp_engine #(
    parameter int ADDR_W  = 32,
    parameter int TAG_W   = 8,
    parameter int DATA_W  = 32,
    parameter int REQ_W   = TAG_W + ADDR_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REQ_W-1:0]  req_dout,
    input  logic              req_empty,
    output logic              req_rd_en,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_err,
    output logic              stray_rvalid,
    output logic [15:0]       resp_count,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, RESP} state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DATA_W / 8 - 1);

    state_t            state;
    logic [ADDR_W-1:0] req_addr;
    logic [TAG_W-1:0]  req_tag;

`ifdef CTRLRD_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

    function automatic logic [DATA_W-1:0] fill_pattern();
        logic [31:0]       word;
        logic [DATA_W-1:0] p;
        word = 32'hDEAD_BEEF;
        for (int i = 0; i < DATA_W; i++) begin
            p[i] = word[i % 32];
        end
        return p;
    endfunction

    localparam logic [DATA_W-1:0] TIMEOUT_DATA = fill_pattern();

    logic [CNT_W-1:0] wait_cnt;
`endif

    assign req_addr = req_dout[ADDR_W-1:0];
    assign req_tag  = req_dout[REQ_W-1:ADDR_W];
    assign busy     = (state != IDLE);

    // Pop only when there is data and the engine can take it this cycle (idle, or retiring a response).
    assign req_rd_en = rst_n && !req_empty &&
                       ((state == IDLE) || ((state == RESP) && resp_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_rd_req   <= 1'b0;
            mem_addr     <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_tag     <= '0;
            resp_err     <= 1'b0;
            stray_rvalid <= 1'b0;
            resp_count   <= '0;
`ifdef CTRLRD_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            mem_rd_req <= 1'b0;
            if (mem_rvalid && (state != WAIT)) begin
                stray_rvalid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!req_empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    mem_addr <= req_addr;
                    resp_tag <= req_tag;
                    if ((req_addr & ALIGN_MASK) != '0) begin
                        resp_err   <= 1'b1;
                        resp_data  <= '0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        mem_rd_req <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef CTRLRD_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        resp_data  <= mem_rdata;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
`ifdef CTRLRD_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        resp_data  <= TIMEOUT_DATA;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_count <= resp_count + 16'd1;
                        state      <= req_empty ? IDLE : LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrlread_resp_engine.sv
// tb/tb_ctrlread_resp_engine.sv - self-checking bench with FIFO/memory models and a response scoreboard.
module tb_ctrlread_resp_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [39:0] req_dout;
    logic        req_empty;
    logic        req_rd_en;
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [7:0]  resp_tag;
    logic        resp_err;
    logic        stray_rvalid;
    logic [15:0] resp_count;
    logic        busy;

    always #5 clk = ~clk;

    ctrlread_resp_engine #(
        .ADDR_W(32), .TAG_W(8), .DATA_W(32), .REQ_W(40)
`ifdef CTRLRD_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_dout(req_dout), .req_empty(req_empty), .req_rd_en(req_rd_en),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag), .resp_err(resp_err),
        .stray_rvalid(stray_rvalid), .resp_count(resp_count), .busy(busy)
    );

    typedef struct {
        logic [7:0]  tag;
        logic [31:0] data;
        logic        err;
    } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [39:0] fifo[$];
    exp_t        expq[$];
    logic [31:0] issue_q[$];
    bit          pop_pending = 0;
    int          mem_cd = -1;
    logic [31:0] mem_pend;
    int          force_lat = 0;
    bit          mem_drop = 0;
    int          cyc_n = 0;
    int          issue_cycle = 0;
    logic [15:0] model_count = 0;
    bit          model_stray = 0;
    bit          held = 0;
    logic [31:0] prev_data;
    logic [7:0]  prev_tag;
    logic        prev_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    task automatic push_req(input logic [7:0] tag, input logic [31:0] addr, input bit to);
        exp_t e;
        fifo.push_back({tag, addr});
        e.tag = tag;
        if (addr[1:0] != 2'b00) begin
            e.data = 32'h0;
            e.err  = 1'b1;
        end else begin
            issue_q.push_back(addr);
            e.data = to ? 32'hDEAD_BEEF : memf(addr);
            e.err  = to;
        end
        expq.push_back(e);
    endtask

    task automatic cyc(input bit rdy, input bit stray_pulse);
        logic [31:0] a;
        exp_t        e;
        @(negedge clk);
        cyc_n++;
        if (pop_pending) begin
            req_dout    = fifo.pop_front();
            pop_pending = 0;
        end
        req_empty  = (fifo.size() == 0);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (mem_cd > 0) begin
            mem_cd--;
            if (mem_cd == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_pend;
                mem_cd     = -1;
            end
        end
        if (stray_pulse) mem_rvalid = 1'b1;
        chk("stray_rvalid", 64'(stray_rvalid), 64'(model_stray));
        chk("resp_count", 64'(resp_count), 64'(model_count));
        if (resp_valid) chk("busy_in_resp", 64'(busy), 64'd1);
        if (mem_rd_req) begin
            chk("rd_req_expected", 64'(issue_q.size() != 0), 64'd1);
            if (issue_q.size() != 0) begin
                a = issue_q.pop_front();
                chk("mem_addr", 64'(mem_addr), 64'(a));
                issue_cycle = cyc_n;
                if (!mem_drop) begin
                    mem_cd   = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
                    mem_pend = memf(a);
                end
            end
        end
        if (held) begin
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_data", 64'(resp_data), 64'(prev_data));
            chk("hold_tag", 64'(resp_tag), 64'(prev_tag));
            chk("hold_err", 64'(resp_err), 64'(prev_err));
        end
        resp_ready = rdy;
        #1;
        if (req_empty) chk("rd_en_while_empty", 64'(req_rd_en), 64'd0);
        if (resp_valid && resp_ready) begin
            chk("resp_expected", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("resp_data", 64'(resp_data), 64'(e.data));
                chk("resp_tag", 64'(resp_tag), 64'(e.tag));
                chk("resp_err", 64'(resp_err), 64'(e.err));
            end
            chk("b2b_pop", 64'(req_rd_en), 64'(!req_empty));
            model_count++;
        end
        if (req_rd_en) begin
            chk("pop_nonempty", 64'(fifo.size() != 0), 64'd1);
            if (fifo.size() != 0) pop_pending = 1;
        end
        held      = resp_valid && !resp_ready;
        prev_data = resp_data;
        prev_tag  = resp_tag;
        prev_err  = resp_err;
        if (stray_pulse) model_stray = 1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((fifo.size() != 0 || expq.size() != 0 || busy || pop_pending) && n < budget) begin
            cyc($urandom_range(0, 3) != 0, 0);
            n++;
        end
        chk("drain_in_budget", 64'(n < budget), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outputs"}, 64'({req_rd_en, mem_rd_req, resp_valid, resp_err, stray_rvalid, busy}), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_resp_data"}, 64'(resp_data), 64'd0);
        chk({tag, "_resp_tag"}, 64'(resp_tag), 64'd0);
        chk({tag, "_resp_count"}, 64'(resp_count), 64'd0);
    endtask

    initial begin
        int          n;
        bit          mis;
        logic [31:0] a;

        rst_n      = 1'b0;
        req_dout   = '0;
        req_empty  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Single read with two-cycle memory latency.
        force_lat = 2;
        push_req(8'h5A, 32'h0000_0100, 0);
        drain(100);
        chk("single_count", 64'(resp_count), 64'd1);
        force_lat = 0;

        // Three queued requests held under backpressure.
        push_req(8'h11, 32'h0000_0200, 0);
        push_req(8'h22, 32'h0000_0204, 0);
        push_req(8'h33, 32'h0000_0208, 0);
        n = 0;
        while (!resp_valid && n < 50) begin
            cyc(0, 0);
            n++;
        end
        chk("bp_resp_seen", 64'(resp_valid), 64'd1);
        repeat (5) cyc(0, 0);
        drain(200);
        chk("bp_count", 64'(resp_count), 64'd4);

        // Misaligned address: error response without memory access.
        push_req(8'h77, 32'h0000_0102, 0);
        drain(100);

        // Stray rvalid while idle, then a normal read.
        cyc(1, 1);
        push_req(8'h44, 32'h0000_0300, 0);
        drain(100);
        chk("stray_sticky", 64'(stray_rvalid), 64'd1);

`ifndef CTRLRD_TIMEOUT_EN
        // Latency beyond any 8-bit bound still completes cleanly.
        force_lat = 300;
        push_req(8'h66, 32'h0000_0400, 0);
        drain(1000);
        force_lat = 0;
`endif

        // Reset while waiting on memory.
        force_lat = 50;
        push_req(8'h99, 32'h0000_0500, 0);
        n = 0;
        while (issue_q.size() != 0 && n < 50) begin
            cyc(1, 0);
            n++;
        end
        cyc(1, 0);
        chk("reset_mid_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        fifo.delete();
        expq.delete();
        issue_q.delete();
        pop_pending = 0;
        mem_cd      = -1;
        mem_rvalid  = 1'b0;
        req_empty   = 1'b1;
        model_count = 0;
        model_stray = 0;
        held        = 0;
        force_lat   = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_busy", 64'(busy), 64'd0);
        push_req(8'hA1, 32'h0000_0600, 0);
        drain(100);
        chk("post_reset_count", 64'(resp_count), 64'd1);

`ifdef CTRLRD_TIMEOUT_EN
        mem_drop = 1;
        push_req(8'hBB, 32'h0000_0700, 1);
        n = 0;
        while (!resp_valid && n < 100) begin
            cyc(0, 0);
            n++;
        end
        chk("timeout_latency", 64'(cyc_n - issue_cycle), 64'd17);
        drain(100);
        mem_drop = 0;
        cyc(1, 1);
        cyc(1, 0);
`endif

        // Randomised mix of aligned/misaligned traffic with random backpressure.
        for (int i = 0; i < 40; i++) begin
            mis = ($urandom_range(0, 3) == 0);
            a   = $urandom & ~32'h3;
            if (mis) a[1:0] = 2'($urandom_range(1, 3));
            push_req(8'($urandom), a, 0);
            repeat ($urandom_range(0, 6)) cyc($urandom_range(0, 3) != 0, 0);
        end
        drain(2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
